ro_sweep_controller: RTL and testbench

//  Sequences the ring-oscillator array and its 16:1 output mux for automated frequency sweeps.
//  For each enabled oscillator index it drives the mux select and the shared s1..s5 configuration.
//  It then pulses start, waits for the oscillator to settle, and counts rising edges of the muxed output over a programmable window.

---
 rtl/ro_ctrl_pkg.sv | 22 ++
 rtl/ro_edge_counter.sv | 62 ++++++
 rtl/ro_sweep_controller.sv | 193 +++++++++++++++++++
 tb/tb_ro_sweep_controller.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ro_ctrl_pkg - shared FSM encoding and geometry defaults for RO sweep control
// Revision: 1.0
// ----------------------------------------------------------------------------
package ro_ctrl_pkg;

  localparam int NUM_RO_DEF = 16;
  localparam int SEL_W_DEF  = 4;
  localparam int CFG_W_DEF  = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    SETUP   = 3'd2,
    SETTLE  = 3'd3,
    MEASURE = 3'd4,
    REPORT  = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ro_edge_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ro_edge_counter - synchronizes the muxed RO clock and counts its rising edges
// Revision: 1.0
// ----------------------------------------------------------------------------
module ro_edge_counter
  import ro_ctrl_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ro_clk_i,
  input  logic             edge_clr_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  logic             sync0_q, sync1_q, prev_q, edge_q;
  logic             edge_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    edge_d  = edge_clr_i ? 1'b0 : (sync1_q & ~prev_q);
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (en_i && edge_q) begin
      if (&count_q) ovf_d = 1'b1;
      else          count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync0_q <= ro_clk_i;
      sync1_q <= sync0_q;
      prev_q  <= sync1_q;
      edge_q  <= edge_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state view so the caller can capture the edge landing on the final window cycle.
  assign count_o = count_d;
  assign ovf_o   = ovf_d;

endmodule
`default_nettype wire

// File: rtl/ro_sweep_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ro_sweep_controller - steps the RO mux through a mask and measures each one
// Revision: 1.0
// ----------------------------------------------------------------------------
module ro_sweep_controller
  import ro_ctrl_pkg::*;
#(
  parameter int NUM_RO        = NUM_RO_DEF,
  parameter int SEL_W         = SEL_W_DEF,
  parameter int CFG_W         = CFG_W_DEF,
  parameter int WIN_W         = 16,
  parameter int CNT_W         = 20,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              go_i,
  input  logic              abort_i,
  input  logic [NUM_RO-1:0] ro_mask_i,
  input  logic [CFG_W-1:0]  cfg_i,
  input  logic [WIN_W-1:0]  window_i,
  input  logic              ro_clk_i,
  output logic [SEL_W-1:0]  ro_sel_o,
  output logic [CFG_W-1:0]  ro_cfg_o,
  output logic              ro_start_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [SEL_W-1:0]  res_idx_o,
  output logic [CNT_W-1:0]  res_count_o,
  output logic              res_ovf_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NUM_RO - 1);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d, sel_q, sel_d, res_idx_q, res_idx_d;
  logic [NUM_RO-1:0]   mask_q, mask_d;
  logic [CFG_W-1:0]    cfg_q, cfg_d, rocfg_q, rocfg_d;
  logic [WIN_W-1:0]    win_q, win_d, timer_q, timer_d;
  logic                start_q, start_d, valid_q, valid_d, ovf_q, ovf_d, done_q, done_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                hit;
  logic [SEL_W-1:0]    hit_idx;
  logic [CNT_W-1:0]    cnt_w;
  logic                ovf_w;

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (wb_clk_i),
    .rst_ni     (wb_rst_ni),
    .ro_clk_i   (ro_clk_i),
    .edge_clr_i (state_q == SETUP),
    .clr_i      (state_q == SETTLE),
    .en_i       (state_q == MEASURE),
    .count_o    (cnt_w),
    .ovf_o      (ovf_w)
  );

  // Lowest enabled oscillator at or above the current index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_RO - 1; i >= 0; i--) begin
      if (mask_q[i] && (SEL_W'(i) >= idx_q)) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    cfg_d     = cfg_q;
    win_d     = win_q;
    timer_d   = timer_q;
    sel_d     = sel_q;
    rocfg_d   = rocfg_q;
    start_d   = start_q;
    valid_d   = valid_q;
    res_idx_d = res_idx_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
      start_d = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (go_i) begin
          mask_d  = ro_mask_i;
          cfg_d   = cfg_i;
          win_d   = window_i;
          idx_d   = '0;
          state_d = SCAN;
        end
        SCAN: if (hit) begin
          idx_d   = hit_idx;
          sel_d   = hit_idx;
          rocfg_d = cfg_q;
          start_d = 1'b0;
          state_d = SETUP;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        SETUP: begin
          start_d = 1'b1;
          timer_d = SETTLE_LAST;
          state_d = SETTLE;
        end
        SETTLE: if (timer_q == '0) begin
          timer_d = (win_q == '0) ? '0 : win_q - 1'b1;
          state_d = MEASURE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
        MEASURE: if (timer_q == '0) begin
          valid_d   = 1'b1;
          res_idx_d = idx_q;
          count_d   = cnt_w;
          ovf_d     = ovf_w;
          state_d   = REPORT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
        REPORT: if (res_ready_i) begin
          valid_d = 1'b0;
          start_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      cfg_q     <= '0;
      win_q     <= '0;
      timer_q   <= '0;
      sel_q     <= '0;
      rocfg_q   <= '0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      res_idx_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      cfg_q     <= cfg_d;
      win_q     <= win_d;
      timer_q   <= timer_d;
      sel_q     <= sel_d;
      rocfg_q   <= rocfg_d;
      start_q   <= start_d;
      valid_q   <= valid_d;
      res_idx_q <= res_idx_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign ro_sel_o    = sel_q;
  assign ro_cfg_o    = rocfg_q;
  assign ro_start_o  = start_q;
  assign res_valid_o = valid_q;
  assign res_idx_o   = res_idx_q;
  assign res_count_o = count_q;
  assign res_ovf_o   = ovf_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_sweep_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ro_sweep_controller - randomized scoreboard bench for ro_sweep_controller
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_ro_sweep_controller;

  localparam int NUM_RO = 16;
  localparam int SEL_W  = 4;
  localparam int CFG_W  = 5;
  localparam int WIN_W  = 16;
  localparam int CNT_W  = 6;
  localparam int SETTLE = 64;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0, rst_n = 1'b0, go = 1'b0, abort = 1'b0;
  logic              ro_clk = 1'b0, ready = 1'b0;
  logic [NUM_RO-1:0] mask = '0;
  logic [CFG_W-1:0]  cfg = '0;
  logic [WIN_W-1:0]  win = '0;
  logic [SEL_W-1:0]  ro_sel, res_idx;
  logic [CFG_W-1:0]  ro_cfg;
  logic [CNT_W-1:0]  res_count;
  logic              ro_start, res_valid, res_ovf, busy, done;

  ro_sweep_controller #(
    .NUM_RO(NUM_RO), .SEL_W(SEL_W), .CFG_W(CFG_W), .WIN_W(WIN_W),
    .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .go_i(go), .abort_i(abort),
    .ro_mask_i(mask), .cfg_i(cfg), .window_i(win), .ro_clk_i(ro_clk),
    .ro_sel_o(ro_sel), .ro_cfg_o(ro_cfg), .ro_start_o(ro_start),
    .res_valid_o(res_valid), .res_ready_i(ready), .res_idx_o(res_idx),
    .res_count_o(res_count), .res_ovf_o(res_ovf), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Oscillator stand-in: period 2*half wb clocks, aligned to the falling edge.
  int half = 4;
  initial forever begin
    repeat (half) @(negedge clk);
    ro_clk = ~ro_clk;
  end

  bit hold_ready = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  typedef struct {
    bit is_done;
    int idx;
    int lo;
    int hi;
  } exp_t;

  exp_t             exp_q[$];
  logic [CFG_W-1:0] exp_cfg = '0;
  int               n_cmp = 0, n_bad = 0;
  bit               mon_en = 1'b0;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted result and every done pulse.
  logic             pv = 0, phs = 0, pstart = 0, pab = 0, povf = 0;
  logic [SEL_W-1:0] pidx = '0;
  logic [CNT_W-1:0] pcnt = '0;
  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      pv = 0; phs = 0; pstart = 0; pab = 0;
    end else begin
      if (phs) chk("valid_clear_after_accept", res_valid == 1'b0, res_valid, 0);
      else if (pv && !pab) begin
        chk("valid_held_until_accept", res_valid == 1'b1, res_valid, 1);
        if (res_valid) begin
          chk("res_idx_stable", res_idx == pidx, res_idx, pidx);
          chk("res_count_stable", res_count == pcnt, res_count, pcnt);
          chk("res_ovf_stable", res_ovf == povf, res_ovf, povf);
        end
      end
      if (res_valid && ready) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          chk("unexpected_result", 1'b0, res_idx, -1);
        end else begin
          exp_t e;
          bit   ok;
          e  = exp_q.pop_front();
          ok = 1'b0;
          for (int n = e.lo; n <= e.hi; n++)
            if (int'(res_count) == ((n > CMAX) ? CMAX : n) && res_ovf == (n > CMAX)) ok = 1'b1;
          chk("result_idx", int'(res_idx) == e.idx, res_idx, e.idx);
          if (!ok)
            $display("FAIL result_count: actual=%0d ovf=%0d required edges %0d..%0d (max %0d)",
                     res_count, res_ovf, e.lo, e.hi, CMAX);
          n_cmp++;
          if (!ok) n_bad++;
        end
      end
      if (done) begin
        bit ok;
        ok = (exp_q.size() != 0) && exp_q[0].is_done;
        chk("done_expected", ok, 1, 0);
        chk("done_while_idle", busy == 1'b0, busy, 0);
        if (ok) void'(exp_q.pop_front());
      end
      if (ro_start && !pstart) begin
        bit ok;
        ok = (exp_q.size() != 0) && !exp_q[0].is_done;
        chk("start_expected", ok, 1, 0);
        if (ok) chk("ro_sel_at_start", int'(ro_sel) == exp_q[0].idx, ro_sel, exp_q[0].idx);
        chk("ro_cfg_at_start", ro_cfg == exp_cfg, ro_cfg, exp_cfg);
      end
      pv = res_valid; phs = res_valid && ready; pstart = ro_start; pab = abort;
      pidx = res_idx; pcnt = res_count; povf = res_ovf;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [NUM_RO-1:0] m);
    for (int i = 0; i < NUM_RO; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic start_sweep(input logic [NUM_RO-1:0] m, input logic [CFG_W-1:0] c,
                             input int w, input int p);
    int weff;
    exp_t e;
    half    = p / 2;
    exp_cfg = c;
    weff    = (w == 0) ? 1 : w;
    for (int i = 0; i < NUM_RO; i++) begin
      if (m[i]) begin
        e.is_done = 0; e.idx = i; e.lo = weff / p; e.hi = (weff + p - 1) / p;
        exp_q.push_back(e);
      end
    end
    e.is_done = 1; e.idx = -1; e.lo = 0; e.hi = 0;
    exp_q.push_back(e);
    mask = m; cfg = c; win = WIN_W'(w); go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, n < budget, n, budget);
    if (n >= budget) begin
      exp_q.delete();
      abort = 1'b1; tick(1); abort = 1'b0; tick(2);
    end
  endtask

  task automatic wait_sig(input string name, input bit want_valid, input int budget);
    int n = 0;
    while (!(want_valid ? res_valid : ro_start) && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, n < budget, n, budget);
  endtask

  task automatic check_abort_state(input string name, input int sel_exp, input logic [CFG_W-1:0] c);
    chk({name, "_busy"}, busy == 1'b0, busy, 0);
    chk({name, "_start"}, ro_start == 1'b0, ro_start, 0);
    chk({name, "_valid"}, res_valid == 1'b0, res_valid, 0);
    chk({name, "_done"}, done == 1'b0, done, 0);
    chk({name, "_sel_kept"}, int'(ro_sel) == sel_exp, ro_sel, sel_exp);
    chk({name, "_cfg_kept"}, ro_cfg == c, ro_cfg, c);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_sel"}, ro_sel == '0, ro_sel, 0);
    chk({name, "_cfg"}, ro_cfg == '0, ro_cfg, 0);
    chk({name, "_start"}, ro_start == 1'b0, ro_start, 0);
    chk({name, "_valid"}, res_valid == 1'b0, res_valid, 0);
    chk({name, "_idx"}, res_idx == '0, res_idx, 0);
    chk({name, "_count"}, res_count == '0, res_count, 0);
    chk({name, "_ovf"}, res_ovf == 1'b0, res_ovf, 0);
    chk({name, "_busy"}, busy == 1'b0, busy, 0);
    chk({name, "_done"}, done == 1'b0, done, 0);
  endtask

  function automatic int budget_for(input logic [NUM_RO-1:0] m, input int w);
    return 300 + $countones(m) * (w + 300);
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_RO-1:0] m;
    logic [CFG_W-1:0]  c;
    int                w, p;

    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick(2);

    // Single oscillator, window 100, ro at wb/8: 12 or 13 edges.
    start_sweep(16'h0001, 5'h0A, 100, 8);
    wait_idle("sweep_single", budget_for(16'h0001, 100));

    // Sparse mask walks 0 -> 8 -> 15.
    start_sweep(16'h8101, 5'h15, 37, 10);
    wait_idle("sweep_8101", budget_for(16'h8101, 37));

    // Empty mask: busy at cycle 1, done at cycle 2.
    start_sweep(16'h0000, 5'h03, 10, 8);
    chk("empty_busy_cycle1", busy == 1'b1, busy, 1);
    chk("empty_no_done_cycle1", done == 1'b0, done, 0);
    tick(1);
    chk("empty_done_cycle2", done == 1'b1, done, 1);
    chk("empty_idle_cycle2", busy == 1'b0, busy, 0);
    wait_idle("sweep_empty", 20);

    // Backpressure: result must stay put for 50 cycles.
    hold_ready = 1'b1;
    start_sweep(16'h0040, 5'h11, 20, 12);
    wait_sig("report_reached", 1'b1, 400);
    tick(50);
    chk("held_valid_after_50", res_valid == 1'b1, res_valid, 1);
    chk("held_busy_after_50", busy == 1'b1, busy, 1);
    hold_ready = 1'b0;
    wait_idle("sweep_backpressure", 300);

    // Abort during SETTLE.
    start_sweep(16'h0A30, 5'h1C, 50, 8);
    wait_sig("settle_reached", 1'b0, 50);
    tick(10);
    abort = 1'b1; tick(1); abort = 1'b0;
    exp_q.delete();
    check_abort_state("abort_settle", 4, 5'h1C);
    tick(5);
    chk("abort_settle_stays_idle", busy == 1'b0, busy, 0);

    // Abort during REPORT drops the pending result.
    hold_ready = 1'b1;
    start_sweep(16'h0200, 5'h07, 15, 8);
    wait_sig("report_reached_abort", 1'b1, 400);
    tick(3);
    abort = 1'b1; tick(1); abort = 1'b0;
    exp_q.delete();
    hold_ready = 1'b0;
    check_abort_state("abort_report", 9, 5'h07);
    tick(5);

    // Normal sweep after abort.
    start_sweep(16'h0006, 5'h19, 64, 14);
    wait_idle("sweep_after_abort", budget_for(16'h0006, 64));

    // go + abort together from IDLE.
    mask = 16'hFFFF; go = 1'b1; abort = 1'b1; tick(1); go = 1'b0; abort = 1'b0;
    chk("go_abort_stay_idle", busy == 1'b0, busy, 0);
    tick(4);
    chk("go_abort_still_idle", busy == 1'b0, busy, 0);

    // go while busy is ignored.
    start_sweep(16'h1010, 5'h0F, 30, 10);
    tick(40);
    mask = 16'h0101; cfg = 5'h10; win = 16'd2; go = 1'b1; tick(1); go = 1'b0;
    wait_idle("sweep_go_while_busy", budget_for(16'h1010, 30));

    // Saturation and window = 0.
    start_sweep(16'h0800, 5'h12, 600, 8);
    wait_idle("sweep_saturate", budget_for(16'h0800, 600));
    start_sweep(16'h4000, 5'h01, 0, 8);
    wait_idle("sweep_window0", budget_for(16'h4000, 0));

    // Reset while measuring.
    start_sweep(16'h0010, 5'h1F, 300, 10);
    wait_sig("settle_reached_rst", 1'b0, 50);
    tick(SETTLE + 20);
    rst_n = 1'b0; tick(1);
    check_zero("midreset");
    tick(2);
    rst_n = 1'b1;
    exp_q.delete();
    tick(2);

    for (int s = 0; s < 12; s++) begin
      m = '0;
      for (int i = 0; i < NUM_RO; i++) m[i] = ($urandom_range(0, 3) == 0);
      c = CFG_W'($urandom);
      w = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 160)) : int'($urandom_range(300, 600));
      p = 2 * int'($urandom_range(4, 8));
      start_sweep(m, c, w, p);
      wait_idle("sweep_random", budget_for(m, w));
      tick(int'($urandom_range(1, 5)));
    end

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
